menu_text_writer: RTL and testbench

Write-side sequencer for the 20x16 on-screen character buffer that the text-overlay stage reads during active video. It accepts simple text commands from game/menu logic (put one character, fill a row, clear the screen), breaks them into one-per-clock writes into the buffer's write port, and issues those writes only while vertical blanking is active, so the overlay never displays a half-updated frame.

---
 rtl/menu_text_writer.sv | 119 +++++++++++
 tb/tb_menu_text_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_text_writer.sv
// Write-side sequencer for the on-screen character buffer: expands PUT / FILL_ROW / CLEAR
// commands into one write per clock, issued only during vertical blanking.
module menu_text_writer #(
    parameter int unsigned COLS = 20,
    parameter int unsigned ROWS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_x,
    input  logic [3:0] cmd_y,
    input  logic [6:0] cmd_char,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [6:0] wr_data,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] OpPut   = 2'b00;
    localparam logic [1:0] OpClear = 2'b01;
    localparam logic [1:0] OpFill  = 2'b10;
    localparam logic [1:0] OpRsvd  = 2'b11;

    localparam logic [4:0] LastCol = 5'(COLS - 1);
    localparam logic [3:0] LastRow = 4'(ROWS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state_q;
    logic [1:0] op_q;
    logic [3:0] row_q;
    logic [4:0] col_q;
    logic [6:0] char_q;
    logic       reject_q;
    logic       last_cell;

    assign cmd_ready = (state_q == StIdle);

    always_comb begin
        last_cell = 1'b0;
        unique case (op_q)
            OpPut:   last_cell = 1'b1;
            OpFill:  last_cell = (col_q == LastCol);
            OpClear: last_cell = (col_q == LastCol) && (row_q == LastRow);
            OpRsvd:  last_cell = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= OpPut;
            row_q    <= '0;
            col_q    <= '0;
            char_q   <= '0;
            reject_q <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        char_q   <= cmd_char;
                        reject_q <= (cmd_op == OpRsvd) || ((cmd_op == OpPut) && (cmd_x > LastCol));
                        row_q    <= (cmd_op == OpClear) ? 4'd0 : cmd_y;
                        col_q    <= (cmd_op == OpPut) ? cmd_x : 5'd0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (reject_q) begin
                        // Rejected commands report immediately, independent of blanking
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state_q <= StDone;
                    end else if (vblnk_in) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {row_q, col_q};
                        wr_data <= char_q;
                        if (last_cell) begin
                            state_q <= StDone;
                        end else if (col_q == LastCol) begin
                            col_q <= 5'd0;
                            row_q <= row_q + 4'd1;
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    // Normal completion pulses done on the first DONE edge; a rejection
                    // already pulsed it on entry, so either way leave once done is high.
                    if (done) begin
                        state_q <= StIdle;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_menu_text_writer.sv
// Bench for menu_text_writer: directed vector table, reset corner cases and random commands
// checked against a cell-list reference model.
module tb_menu_text_writer;

    localparam int COLS = 20;
    localparam int ROWS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk_in = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [4:0] cmd_x = '0;
    logic [3:0] cmd_y = '0;
    logic [6:0] cmd_char = '0;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [6:0] wr_data;
    logic       done;
    logic       err;

    menu_text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_char  (cmd_char),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    int got_q[$];
    int n_done, got_err, stray_err, vb_bad, ready_bad, timed_out, lat, last_wr;

    typedef struct {
        logic [1:0] op;
        int         x;
        int         y;
        int         ch;
        int         mode;   // 0 vblnk high, 1 toggle every 50 cycles, 2 random
        bit         hold;
        int         n;
        bit         rej;
        int         first;
        int         last;
        int         lat;    // -1: not fixed
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic bit is_reject(input logic [1:0] op, input int x);
        return (op == 2'b11) || ((op == 2'b00) && (x >= COLS));
    endfunction

    // Reference: list of {addr, data} the command must produce, in order.
    function automatic void build_expected(input logic [1:0] op, input int x, input int y,
                                           input int ch);
        exp_q.delete();
        if (is_reject(op, x)) return;
        case (op)
            2'b00: exp_q.push_back(((y * 32 + x) << 7) | ch);
            2'b10: for (int c = 0; c < COLS; c++) exp_q.push_back(((y * 32 + c) << 7) | ch);
            2'b01:
                for (int i = 0; i < COLS * ROWS; i++)
                    exp_q.push_back((((i / COLS) * 32 + (i % COLS)) << 7) | ch);
            default: ;
        endcase
    endfunction

    function automatic logic vb_value(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((k / 50) % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input int x, input int y, input int ch,
                           input int mode, input bit hold);
        int  cyc;
        int  wait_n;
        int  done_cyc;
        logic vb_used;
        got_q.delete();
        n_done = 0; got_err = 0; stray_err = 0; vb_bad = 0; ready_bad = 0;
        timed_out = 0; last_wr = 0; done_cyc = 0; lat = 0;
        wait_n = 0;
        while (!cmd_ready && wait_n < 1000) begin
            @(negedge clk);
            wait_n++;
        end
        if (!cmd_ready) begin
            timed_out = 1;
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x[4:0];
        cmd_y     = y[3:0];
        cmd_char  = ch[6:0];
        @(negedge clk);
        if (cmd_ready) ready_bad++;
        if (!hold) cmd_valid = 1'b0;
        cyc = 0;
        vb_used = vb_value(mode, 1);
        vblnk_in = vb_used;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_en) begin
                if (!vb_used) vb_bad++;
                got_q.push_back(int'({wr_addr, wr_data}));
                last_wr = cyc;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    done_cyc = cyc;
                    got_err  = int'(err);
                end
            end else if (err) begin
                stray_err++;
            end
            if (n_done > 0 && cyc == done_cyc + 1) begin
                if (!cmd_ready) ready_bad++;
                break;
            end
            if (cmd_ready) ready_bad++;
            if (cyc > 4000) begin
                timed_out = 1;
                break;
            end
            vb_used = vb_value(mode, cyc + 1);
            vblnk_in = vb_used;
            if (hold) begin
                cmd_op   = 2'($urandom_range(0, 3));
                cmd_x    = 5'($urandom_range(0, 31));
                cmd_y    = 4'($urandom_range(0, 15));
                cmd_char = 7'($urandom_range(0, 127));
            end
        end
        cmd_valid = 1'b0;
        lat = done_cyc;
    endtask

    task automatic verify(input string name, input logic [1:0] op, input int x, input int y,
                          input int ch);
        int mism;
        int n;
        build_expected(op, x, y, ch);
        check({name, " timeout"}, timed_out, 0);
        check({name, " write count"}, got_q.size(), exp_q.size());
        mism = 0;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) mism++;
        check({name, " write seq mismatches"}, mism, 0);
        check({name, " write in vblank low"}, vb_bad, 0);
        check({name, " done pulses"}, n_done, 1);
        check({name, " err"}, got_err, int'(is_reject(op, x)));
        check({name, " stray err"}, stray_err, 0);
        check({name, " cmd_ready timing"}, ready_bad, 0);
        check({name, " done latency"}, lat, is_reject(op, x) ? 1 : last_wr + 1);
    endtask

    initial begin
        tbl[0] = '{2'b00, 3, 2, 'h41, 0, 1'b0, 1, 1'b0, 'h043, 'h043, 2};
        tbl[1] = '{2'b10, 0, 15, 'h2D, 0, 1'b0, 20, 1'b0, 'h1E0, 'h1F3, 21};
        tbl[2] = '{2'b00, 20, 5, 'h11, 0, 1'b0, 0, 1'b1, 0, 0, 1};
        tbl[3] = '{2'b11, 4, 4, 'h22, 0, 1'b0, 0, 1'b1, 0, 0, 1};
        tbl[4] = '{2'b00, 19, 15, 'h55, 0, 1'b0, 1, 1'b0, 'h1F3, 'h1F3, 2};
        tbl[5] = '{2'b10, 9, 0, 'h7F, 0, 1'b0, 20, 1'b0, 'h000, 'h013, 21};
        tbl[6] = '{2'b01, 0, 0, 'h20, 1, 1'b0, 320, 1'b0, 'h000, 'h1F3, -1};
        tbl[7] = '{2'b01, 7, 3, 'h2E, 0, 1'b0, 320, 1'b0, 'h000, 'h1F3, 321};
        tbl[8] = '{2'b10, 0, 7, 'h33, 2, 1'b1, 20, 1'b0, 'h0E0, 'h0F3, -1};
        tbl[9] = '{2'b00, 31, 1, 'h0A, 2, 1'b0, 0, 1'b1, 0, 0, 1};

        // Reset with random inputs: everything idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vblnk_in  = 1'($urandom_range(0, 1));
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_x     = 5'($urandom_range(0, 31));
            cmd_y     = 4'($urandom_range(0, 15));
            cmd_char  = 7'($urandom_range(0, 127));
            check("reset outputs", int'({cmd_ready, wr_en, wr_addr, wr_data, done, err}), 'h80000);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vblnk_in  = 1'b1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].ch, tbl[i].mode, tbl[i].hold);
            verify(nm, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].ch);
            check({nm, " n"}, got_q.size(), tbl[i].n);
            check({nm, " err flag"}, got_err, int'(tbl[i].rej));
            if (tbl[i].n > 0 && got_q.size() > 0) begin
                check({nm, " first addr"}, got_q[0] >> 7, tbl[i].first);
                check({nm, " last addr"}, got_q[got_q.size() - 1] >> 7, tbl[i].last);
            end
            if (tbl[i].lat >= 0) check({nm, " fixed latency"}, lat, tbl[i].lat);
        end

        // Reset in the middle of a CLEAR, right after the 100th write
        begin
            int wcount;
            int guard;
            bit dseen;
            guard = 0;
            while (!cmd_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            vblnk_in  = 1'b1;
            cmd_valid = 1'b1;
            cmd_op    = 2'b01;
            cmd_char  = 7'h20;
            @(negedge clk);
            cmd_valid = 1'b0;
            wcount = 0;
            guard  = 0;
            while (wcount < 100 && guard < 400) begin
                @(negedge clk);
                guard++;
                if (wr_en) wcount++;
            end
            check("midreset write count", wcount, 100);
            #2 rst = 1'b0;
            #1;
            check("midreset wr_en async", int'(wr_en), 0);
            check("midreset cmd_ready", int'(cmd_ready), 1);
            check("midreset wr_addr", int'(wr_addr), 0);
            dseen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done || wr_en) dseen = 1'b1;
            end
            check("midreset no done", int'(dseen), 0);
            rst = 1'b1;
            run_cmd(2'b00, 5, 9, 'h61, 0, 1'b0);
            verify("post-reset put", 2'b00, 5, 9, 'h61);
            check("post-reset put latency", lat, 2);
        end

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            int x, y, ch, mode;
            bit hold;
            op = 2'($urandom_range(0, 3));
            if (op == 2'b01 && $urandom_range(0, 2) != 0) op = 2'b00;
            x    = $urandom_range(0, 31);
            y    = $urandom_range(0, 15);
            ch   = $urandom_range(0, 127);
            mode = $urandom_range(0, 2);
            hold = 1'($urandom_range(0, 1));
            run_cmd(op, x, y, ch, mode, hold);
            verify($sformatf("rand%0d", i), op, x, y, ch);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
